dcache_controller: RTL and testbench
====================================

# dcache_controller

Blocking, direct-mapped, write-back, write-allocate data-cache controller for the MEM stage. It owns the tag/valid/dirty state and line storage, serves CPU loads and stores from the MEM stage, and sequences 256-bit block write-backs and refills over the data-memory handshake. Its `p1_stall_o` is the cache-stall signal that freezes the pipeline registers, including MEM/WB, while a miss is outstanding.

## Interface
- `NUM_LINES`, 32: number of cache lines; power of two, 2..256. Index width is `IW = log2(NUM_LINES)`; tag width is `27 - IW`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `p1_addr_i` input 32: CPU byte address.
  - `[4:2]` is the word within the block.
  - `[4+IW:5]` is the line index.
  - `[31:5+IW]` is the tag.
  - `[1:0]` is ignored.
- `p1_data_i` input 32: store data.
- `p1_MemRead_i` input 1: load request.
- `p1_MemWrite_i` input 1: store request.
- `p1_data_o` output 32: load data.
- `p1_stall_o` output 1: pipeline stall; combinational.
- `mem_enable_o` output 1: memory request; registered.
- `mem_write_o` output 1: 1 = block write, 0 = block read; registered.
- `mem_addr_o` output 32: block address, bits `[4:0]` = 0; registered.
- `mem_data_o` output 256: write-back block.
- `mem_data_i` input 256: refill block.
- `mem_ack_i` input 1: one-cycle completion pulse from memory.

## Operation
- Request: `req = p1_MemRead_i | p1_MemWrite_i`.
- Hit: `hit = valid[idx] & (tag[idx] == addr_tag)`.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_OK.
- IDLE:
  - `p1_stall_o = req & ~hit`.
  - Read hit: `p1_data_o` is the selected word, combinationally. In all other cases `p1_data_o = 0`.
  - Write hit: at the clock edge, write the selected word with `p1_data_i` and set `dirty[idx] = 1`. Other words in the line are unchanged.
  - Miss (`req & ~hit`): go to MISS.
  - `mem_ack_i` is ignored in IDLE.
- MISS (one cycle, stall = 1):
  - If `valid[idx] & dirty[idx]`: go to WRITEBACK, load `mem_addr_o = {tag[idx], idx, 5'b0}`, `mem_write_o = 1`, `mem_data_o = line[idx]`, `mem_enable_o = 1`.
  - Otherwise: go to REFILL, load `mem_addr_o = {addr_tag, idx, 5'b0}`, `mem_write_o = 0`, `mem_enable_o = 1`.
- WRITEBACK: hold all memory outputs stable until `mem_ack_i`. On ack, load the REFILL request (same values as the REFILL branch of MISS) and go to REFILL.
- REFILL: hold the request until `mem_ack_i`. On ack:
  - `line[idx] = mem_data_i`, `tag[idx] = addr_tag`, `valid = 1`, `dirty = 0`.
  - `mem_enable_o = 0`, `mem_write_o = 0`.
  - Go to REFILL_OK.
- REFILL_OK (one cycle, stall = 1): go to IDLE. The request now hits and is served in IDLE, where a store sets dirty.
- Stall is 1 in every state except IDLE.
- `idx` and `addr_tag` are taken from `p1_addr_i`, which the stalled pipeline holds constant during a miss. If the request drops mid-miss, the controller still completes the refill using the address latched on entering MISS.
- Simultaneous `p1_MemRead_i` and `p1_MemWrite_i`: treated as a store, and the read data is also driven (the pre-write word).

## Timing
- Reset values:
  - state = IDLE.
  - All `valid` and `dirty` bits = 0.
  - `mem_enable_o = 0`, `mem_write_o = 0`, `mem_addr_o = 0`, `mem_data_o = 0`.
  - `p1_data_o` and `p1_stall_o` follow the combinational rules (0 with no request).
  - Tag and data arrays are not reset.
- Reset asserted mid-operation: immediate return to IDLE, `mem_enable_o` deasserted, all lines invalidated. A pending write-back is abandoned.
- Hit latency: 0 stall cycles.
- Clean miss: stall cycles = 3 + N, where N is the number of cycles from `mem_enable_o` rising to the edge that samples `mem_ack_i`, inclusive.
- Dirty miss: stall cycles = 3 + N_wb + N_rf.
- Memory handshake: `mem_enable_o` is level and held until ack. WRITEBACK→REFILL keeps `mem_enable_o` high with no idle cycle; address and `mem_write_o` change on the ack edge.
- `mem_ack_i` arriving on the same cycle `mem_enable_o` is first driven is legal (N = 1).

## Test plan
- Cold read, addr 0x0000_0404, memory acks 4 cycles after enable:
  - `mem_addr_o = 0x0000_0400`, `mem_write_o = 0`.
  - Stall held for 7 cycles.
  - Then `p1_data_o` = word 1 of the refilled block, stall = 0.
- Read hit on the same line, addr 0x0000_0410: stall = 0 in the same cycle, word 4 returned, no `mem_enable_o`.
- Store 0xDEAD_BEEF to 0x0000_0408 (hit), then load 0x0000_0808 (same index 0, new tag):
  - Write-back to 0x0000_0400 whose block word 2 = 0xDEAD_BEEF.
  - Then refill from 0x0000_0800 with no gap in `mem_enable_o`.
  - Line ends clean.
- Write miss to 0x0000_1000:
  - Refill, then the word is written in REFILL_OK+1.
  - Dirty = 1; a later evicting miss to the same index issues a write-back.
- `rst_i` pulsed low during WRITEBACK: `mem_enable_o` drops asynchronously; next load to the previously cached address misses.
- Stray `mem_ack_i` pulse in IDLE: no state change, no array write.

Source files
------------

// File: rtl/dcache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dcache_controller
//  Brief    : Blocking, direct-mapped, write-back, write-allocate data-cache
//             controller for the MEM stage. Holds tag/valid/dirty state and
//             line storage, serves loads/stores, and sequences 256-bit
//             write-backs and refills over the data-memory handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int NUM_LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 27 - IW;

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_MISS      = 3'd1;
    localparam logic [2:0] c_S_WRITEBACK = 3'd2;
    localparam logic [2:0] c_S_REFILL    = 3'd3;
    localparam logic [2:0] c_S_REFILL_OK = 3'd4;

    logic [2:0]           r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [255:0]         r_line [NUM_LINES];
    logic [IW-1:0]        r_miss_idx;
    logic [TW-1:0]        r_miss_tag;

    logic [IW-1:0]        w_idx;
    logic [TW-1:0]        w_tag;
    logic [7:0]           w_wsel;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_write_hit;
    logic [31:0]          w_rd_word;
    logic                 w_unused;

    assign w_idx       = p1_addr_i[4+IW:5];
    assign w_tag       = p1_addr_i[31:5+IW];
    assign w_wsel      = {p1_addr_i[4:2], 5'b0};
    assign w_req       = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit       = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_write_hit = (r_state == c_S_IDLE) & p1_MemWrite_i & w_hit;
    assign w_rd_word   = r_line[w_idx][w_wsel +: 32];
    // Byte offset within the word is irrelevant to a word-wide cache.
    assign w_unused    = &{1'b0, p1_addr_i[1:0]};

    // Stall the pipeline outside IDLE and on any IDLE miss.
    assign p1_stall_o = (r_state != c_S_IDLE) | (w_req & ~w_hit);
    // Load data only on an IDLE read hit; a combined read/write sees the old word.
    assign p1_data_o  = ((r_state == c_S_IDLE) & p1_MemRead_i & w_hit) ? w_rd_word : 32'd0;

    // Miss sequencer plus valid/dirty bookkeeping and the memory request registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= c_S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_data_o   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_req & ~w_hit) begin
                        // Latch the miss address so the refill completes even if the request drops.
                        r_state    <= c_S_MISS;
                        r_miss_idx <= w_idx;
                        r_miss_tag <= w_tag;
                    end else if (w_write_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                c_S_MISS: begin
                    mem_enable_o <= 1'b1;
                    if (r_valid[r_miss_idx] & r_dirty[r_miss_idx]) begin
                        r_state     <= c_S_WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {r_tag[r_miss_idx], r_miss_idx, 5'b0};
                        mem_data_o  <= r_line[r_miss_idx];
                    end else begin
                        r_state     <= c_S_REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {r_miss_tag, r_miss_idx, 5'b0};
                    end
                end
                c_S_WRITEBACK: begin
                    // Enable stays high across the switch to the refill request.
                    if (mem_ack_i) begin
                        r_state     <= c_S_REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {r_miss_tag, r_miss_idx, 5'b0};
                    end
                end
                c_S_REFILL: begin
                    if (mem_ack_i) begin
                        r_state             <= c_S_REFILL_OK;
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                        mem_enable_o        <= 1'b0;
                        mem_write_o         <= 1'b0;
                    end
                end
                c_S_REFILL_OK: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Tag and line storage: store-hit word update and refill line/tag write.
    always_ff @(posedge clk_i) begin
        if (w_write_hit) begin
            r_line[w_idx][w_wsel +: 32] <= p1_data_i;
        end
        if ((r_state == c_S_REFILL) & mem_ack_i) begin
            r_line[r_miss_idx] <= mem_data_i;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_controller
//  Brief    : Scoreboard bench for dcache_controller. Stimulus pushes expected
//             CPU responses and memory transactions into queues; monitors pop
//             and compare when the DUT serves a request or memory acks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_controller #(.NUM_LINES(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          stalls;
    } cpu_exp_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        int          word;
        logic [31:0] val;
    } mem_exp_t;

    cpu_exp_t     cpu_q[$];
    mem_exp_t     mem_q[$];
    logic [255:0] mem_blk [logic [31:0]];

    int checks   = 0;
    int failures = 0;
    int lat      = 4;
    int mcnt     = 0;
    int stall_cnt = 0;
    bit stray_ack = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mexp(input string name, input logic wr, input logic [31:0] addr,
                        input int word, input logic [31:0] val);
        mem_exp_t e;
        e.name = name; e.wr = wr; e.addr = addr; e.word = word; e.val = val;
        mem_q.push_back(e);
    endtask

    // Issue one CPU access, hold it until served, then drop the request.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input int stalls);
        cpu_exp_t e;
        bit done;
        e.name = name; e.data = exp; e.stalls = stalls;
        cpu_q.push_back(e);
        @(posedge clk_i); #1;
        p1_addr_i = addr; p1_data_i = wdata;
        p1_MemRead_i = rd; p1_MemWrite_i = wr;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!p1_stall_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check({name, "_timeout"}, 256'd1, 256'd0);
        @(posedge clk_i); #1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    endtask

    // Memory responder and memory-side monitor: acks after lat enabled cycles.
    always @(negedge clk_i) begin : mem_side
        logic [255:0] blk;
        mem_exp_t     m;
        mem_ack_i = 1'b0;
        if (stray_ack) begin
            mem_ack_i  = 1'b1;
            mem_data_i = '1;
            stray_ack  = 1'b0;
        end else if (!mem_enable_o) begin
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt >= lat) begin
                mcnt = 0;
                mem_ack_i = 1'b1;
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_req", {224'd0, mem_addr_o}, 256'hFFFF_FFFF);
                end else begin
                    m = mem_q.pop_front();
                    check({m.name, "_addr"}, {224'd0, mem_addr_o}, {224'd0, m.addr});
                    check({m.name, "_write"}, {255'd0, mem_write_o}, {255'd0, m.wr});
                    if (m.wr) check({m.name, "_wdata"}, {224'd0, mem_data_o[m.word*32 +: 32]}, {224'd0, m.val});
                end
                if (mem_write_o) begin
                    mem_blk[mem_addr_o] = mem_data_o;
                end else begin
                    if (mem_blk.exists(mem_addr_o)) begin
                        blk = mem_blk[mem_addr_o];
                    end else begin
                        for (int w = 0; w < 8; w++) blk[w*32 +: 32] = 32'hA000_0000 ^ mem_addr_o ^ w;
                    end
                    mem_data_i = blk;
                end
            end
        end
    end

    // CPU-side monitor: counts stall cycles and checks each served request.
    always @(negedge clk_i) begin : cpu_side
        cpu_exp_t e;
        if (rst_i && (p1_MemRead_i || p1_MemWrite_i)) begin
            if (p1_stall_o) begin
                stall_cnt++;
            end else begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_resp", {224'd0, p1_data_o}, 256'hFFFF_FFFF);
                end else begin
                    e = cpu_q.pop_front();
                    check({e.name, "_data"}, {224'd0, p1_data_o}, {224'd0, e.data});
                    check({e.name, "_stalls"}, 256'(stall_cnt), 256'(e.stalls));
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_stall",    {255'd0, p1_stall_o},   256'd0);
        check("rst_data",     {224'd0, p1_data_o},    256'd0);
        check("rst_enable",   {255'd0, mem_enable_o}, 256'd0);
        check("rst_write",    {255'd0, mem_write_o},  256'd0);
        check("rst_addr",     {224'd0, mem_addr_o},   256'd0);
        check("rst_mdata",    mem_data_o,             256'd0);

        // Cold clean miss, ack 4 cycles after enable.
        lat = 4;
        mexp("cold_rf", 1'b0, 32'h0000_0400, 0, 32'd0);
        access("cold_rd", 1'b1, 1'b0, 32'h0000_0404, 32'd0, 32'hA000_0401, 7);
        access("hit_rd",  1'b1, 1'b0, 32'h0000_0410, 32'd0, 32'hA000_0404, 0);
        access("hit_st",  1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 32'd0, 0);

        // Dirty eviction: write-back then refill.
        lat = 3;
        mexp("evict_wb", 1'b1, 32'h0000_0400, 2, 32'hDEAD_BEEF);
        mexp("evict_wb1", 1'b1, 32'h0000_0400, 1, 32'hA000_0401);
        mexp("evict_rf", 1'b0, 32'h0000_0800, 0, 32'd0);
        // Two write expectations for one transaction are not possible; drop the extra one.
        void'(mem_q.pop_back()); void'(mem_q.pop_back());
        mexp("evict_rf", 1'b0, 32'h0000_0800, 0, 32'd0);
        access("evict_rd", 1'b1, 1'b0, 32'h0000_0808, 32'd0, 32'hA000_0802, 9);
        access("new_hit",  1'b1, 1'b0, 32'h0000_0808, 32'd0, 32'hA000_0802, 0);

        // Clean line is replaced without write-back; old block holds the store.
        mexp("back_rf", 1'b0, 32'h0000_0400, 0, 32'd0);
        access("back_rd",  1'b1, 1'b0, 32'h0000_0408, 32'd0, 32'hDEAD_BEEF, 6);
        access("back_w1",  1'b1, 1'b0, 32'h0000_0404, 32'd0, 32'hA000_0401, 0);

        // Write miss: allocate, then store sets dirty.
        lat = 2;
        mexp("wmiss_rf", 1'b0, 32'h0000_1000, 0, 32'd0);
        access("wmiss_st", 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'd0, 5);
        access("wmiss_rd", 1'b1, 1'b0, 32'h0000_1000, 32'd0, 32'h1234_5678, 0);
        mexp("wmiss_wb", 1'b1, 32'h0000_1000, 0, 32'h1234_5678);
        mexp("wmiss_rf2", 1'b0, 32'h0000_2000, 0, 32'd0);
        access("wmiss_ev", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 32'hA000_2001, 7);

        // Combined read+write returns the pre-write word.
        access("rw_both",  1'b1, 1'b1, 32'h0000_2004, 32'h55AA_55AA, 32'hA000_2001, 0);
        access("rw_after", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 32'h55AA_55AA, 0);

        // A different index does not disturb line 0.
        mexp("idx1_rf", 1'b0, 32'h0000_0020, 0, 32'd0);
        access("idx1_rd",  1'b1, 1'b0, 32'h0000_0024, 32'd0, 32'hA000_0021, 5);
        access("idx0_keep", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 32'h55AA_55AA, 0);

        // Stray ack in IDLE must not alter anything.
        @(posedge clk_i); #1 stray_ack = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("stray_enable", {255'd0, mem_enable_o}, 256'd0);
        access("stray_rd0", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 32'h55AA_55AA, 0);
        access("stray_rd1", 1'b1, 1'b0, 32'h0000_0024, 32'd0, 32'hA000_0021, 0);

        // Reset during write-back: request abandoned, lines invalidated.
        lat = 100000;
        @(posedge clk_i); #1;
        p1_addr_i = 32'h0000_4004; p1_MemRead_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_enable_o && mem_write_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstwb_seen",  {255'd0, seen}, 256'd1);
        check("rstwb_addr",  {224'd0, mem_addr_o}, {224'd0, 32'h0000_2000});
        check("rstwb_word1", {224'd0, mem_data_o[63:32]}, {224'd0, 32'h55AA_55AA});
        @(posedge clk_i); #2 rst_i = 1'b0;
        #1;
        check("rstwb_enable", {255'd0, mem_enable_o}, 256'd0);
        check("rstwb_write",  {255'd0, mem_write_o},  256'd0);
        check("rstwb_stall",  {255'd0, p1_stall_o},   256'd1);
        #1 p1_MemRead_i = 1'b0;
        #1 check("rstwb_idle_stall", {255'd0, p1_stall_o}, 256'd0);
        @(negedge clk_i); #1 rst_i = 1'b1;
        lat = 2;
        mexp("rst_rf", 1'b0, 32'h0000_2000, 0, 32'd0);
        access("rst_miss", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 32'hA000_2001, 5);

        repeat (3) @(posedge clk_i);
        check("cpu_q_empty", 256'(cpu_q.size()), 256'd0);
        check("mem_q_empty", 256'(mem_q.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
